// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x3 matrix keypad scanner with debounce, key code and one-clock dav strobe (auto-repeat when KEYPAD_REPEAT_EN is defined)
module keypad_scanner #(
    parameter int SCAN_DIV       = 100000,
    parameter int DEBOUNCE_TICKS = 8,
    parameter int REPEAT_TICKS   = 250
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [2:0] col,
    output logic [3:0] row,
    output logic [3:0] KeypadData,
    output logic       dav,
    output logic       key_held
);
    typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED, RELEASE} state_t;
    localparam int PW = $clog2(SCAN_DIV);
    localparam int DW = $clog2(DEBOUNCE_TICKS + 1);
    localparam logic [PW-1:0] P_LAST = PW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_TICKS - 1);
    state_t state, state_n;
    logic [2:0] col_m, col_s, cand, pat;
    logic [PW-1:0] pcnt;
    logic [DW-1:0] dcnt;
    logic [1:0] ridx, cidx;
    logic [3:0] code;
    logic tick, one_low, idle, same, last, rpt_fire;
    assign tick    = pcnt == P_LAST;
    assign one_low = col_s == 3'b110 || col_s == 3'b101 || col_s == 3'b011;
    assign idle    = col_s == 3'b111;
    assign same    = col_s == cand;
    assign last    = dcnt == D_LAST;
    assign pat     = state == SCAN ? col_s : cand;
    assign cidx    = !pat[0] ? 2'd0 : !pat[1] ? 2'd1 : 2'd2;
    assign code    = ridx == 2'd3 ? (cidx == 2'd0 ? 4'hA : cidx == 2'd1 ? 4'h0 : 4'hB)
                                  : {2'b00, ridx} * 4'd3 + {2'b00, cidx} + 4'd1;
    // two-flop synchronizer for the asynchronous column inputs
    always_ff @(posedge clock or posedge reset)
        if (reset) {col_s, col_m} <= 6'b111111;
        else {col_s, col_m} <= {col_m, col};
    // free-running scan prescaler
    always_ff @(posedge clock or posedge reset)
        if (reset) pcnt <= '0;
        else pcnt <= tick ? '0 : pcnt + 1'b1;
    // state register
    always_ff @(posedge clock or posedge reset)
        if (reset) state <= SCAN;
        else state <= state_n;
    // next state: everything but PRESSED moves only on a scan tick
    always_comb begin
        state_n = state;
        case (state)
            SCAN:     if (tick && one_low) state_n = DEBOUNCE_TICKS == 1 ? PRESSED : DEBOUNCE;
            DEBOUNCE: if (tick) state_n = !same ? SCAN : last ? PRESSED : DEBOUNCE;
            PRESSED:  state_n = RELEASE;
            RELEASE:  if (tick && idle && last) state_n = SCAN;
        endcase
    end
    // row index, candidate column, debounce/release counter and key code register
    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            ridx       <= '0;
            cand       <= 3'b111;
            dcnt       <= '0;
            KeypadData <= 4'h0;
        end else begin
            if (tick && state_n == SCAN) ridx <= ridx + 1'b1;
            if (state == SCAN && state_n != SCAN) cand <= col_s;
            if (state == SCAN) dcnt <= DW'(1);
            else if (state == PRESSED) dcnt <= '0;
            else if (tick && state == DEBOUNCE) dcnt <= dcnt + 1'b1;
            else if (tick && state == RELEASE) dcnt <= idle ? dcnt + 1'b1 : '0;
            if (state_n == PRESSED) KeypadData <= code;
        end
`ifdef KEYPAD_REPEAT_EN
    localparam int RW = $clog2(REPEAT_TICKS + 1);
    localparam logic [RW-1:0] R_LAST = RW'(REPEAT_TICKS - 1);
    logic [RW-1:0] rcnt;
    assign rpt_fire = state == RELEASE && tick && same && rcnt == R_LAST;
    // repeat counter advances on ticks while the original key stays pressed
    always_ff @(posedge clock or posedge reset)
        if (reset) rcnt <= '0;
        else if (state != RELEASE || (tick && idle) || rpt_fire) rcnt <= '0;
        else if (tick && same) rcnt <= rcnt + 1'b1;
`else
    assign rpt_fire = 1'b0;
`endif
    // outputs: one-cold row drive, strobe and held flag
    always_comb begin
        row      = ~(4'b0001 << ridx);
        key_held = state == PRESSED || state == RELEASE;
        dav      = state == PRESSED || rpt_fire;
    end
endmodule
